muldiv_unit: RTL

- Iterative RV32M execute unit. Consumes the two source operands read from the register file (rs1_data, rs2_data) plus funct3.
- Produces a 32-bit result for the write-back path, which writes it into rd.
- Multi-cycle: one operand bit per cycle for both multiply and divide.
- Start/busy/done handshake lets the control unit stall the pipeline while the unit works.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/muldiv_unit_if.sv | 23 ++
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: M-extension funct3 codes, muldiv FSM state type, XLEN.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the pipeline control and the muldiv unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_data, rs2_data, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one operand bit per cycle, shared
// magnitude registers and a single 2*XLEN accumulator for both datapaths.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  import riscv_pkg::*;

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              neg;
  logic [2*XLEN-1:0] acc;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  // Operand decode for the accept edge
  logic            a_signed, b_signed, a_neg, b_neg, sign_in;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_val;

  always_comb begin
    a_signed = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU) ||
               (bus.funct3 == F3_DIV)  || (bus.funct3 == F3_REM);
    b_signed = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_DIV) ||
               (bus.funct3 == F3_REM);
    a_neg    = a_signed & bus.rs1_data[XLEN-1];
    b_neg    = b_signed & bus.rs2_data[XLEN-1];
    // Negating INT_MIN wraps back to INT_MIN, which is the correct unsigned magnitude
    a_abs    = a_neg ? -bus.rs1_data : bus.rs1_data;
    b_abs    = b_neg ? -bus.rs2_data : bus.rs2_data;
    sign_in  = (bus.funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero = bus.funct3[2] && (bus.rs2_data == '0);
    div_ovf  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
               (bus.rs1_data == INT_MIN) && (bus.rs2_data == '1);
    special  = div_zero || div_ovf;
    special_val = '0;
    if (div_zero)
      special_val = bus.funct3[1] ? bus.rs1_data : '1;
    else if (div_ovf)
      special_val = bus.funct3[1] ? '0 : bus.rs1_data;
  end

  // One iteration step; the low half holds the multiplier (mul) or dividend/quotient (div)
  logic [XLEN-1:0]   hi, lo;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    hi        = acc[2*XLEN-1:XLEN];
    lo        = acc[XLEN-1:0];
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : '0);
    mul_next  = {mul_sum, lo[XLEN-1:1]};
    div_shift = {hi, lo[XLEN-1]};
    div_ge    = div_shift >= {1'b0, b_mag};
    div_diff  = div_shift[XLEN-1:0] - b_mag;
    div_next  = {(div_ge ? div_diff : div_shift[XLEN-1:0]), lo[XLEN-2:0], div_ge};
  end

  // Sign correction and result selection for the FIX state
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  always_comb begin
    prod_fix = neg ? -acc : acc;
    quo_fix  = neg ? -lo : lo;
    rem_fix  = neg ? -hi : hi;
    case (op)
      F3_MUL:                       fix_val = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_val = quo_fix;
      default:                      fix_val = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op       <= F3_MUL;
      a_mag    <= '0;
      b_mag    <= '0;
      neg      <= 1'b0;
      acc      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
          if (!bus.flush && bus.start) begin
            op    <= bus.funct3;
            a_mag <= a_abs;
            b_mag <= b_abs;
            neg   <= sign_in;
            if (special) begin
              result_q <= special_val;
              done_q   <= 1'b1;
              state    <= S_DONE;
            end else begin
              busy_q <= 1'b1;
              cnt    <= '0;
              acc    <= {{XLEN{1'b0}}, (bus.funct3[2] ? a_abs : b_abs)};
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            acc <= op[2] ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN-1))
              state <= S_FIX;
          end
        end
        S_FIX: begin
          busy_q <= 1'b0;
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            result_q <= fix_val;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
